inta_sequencer: RTL

CPU-side interrupt-acknowledge sequencer for the 8259 PIC subsystem. It drives the other end of the INTA protocol that the PIC cascade and vector logic respond to. When the master PIC raises INT and interrupts are enabled, it issues the two active-low INTA pulses with programmable width and gap. It samples the 8-bit vector from the data bus during the second pulse and presents the vector to the core with a one-cycle valid strobe.

---
 rtl/inta_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/inta_sequencer.sv
// -----------------------------------------------------------------------------
// inta_sequencer
//
// CPU-side interrupt-acknowledge sequencer for the 8259 PIC subsystem. When
// the master PIC raises INT while interrupts are enabled, it issues two
// active-low INTA pulses (PULSE_W cycles low, GAP_W cycles high between them).
// It captures the vector from the data bus at the last edge of the second
// pulse and presents it with a one-cycle strobe. The FSM then waits RECOVER_W
// cycles before INT is looked at again.
//
// Parameters:
//   PULSE_W    cycles each INTA pulse is held low          (1..15)
//   GAP_W      cycles INTA is high between the two pulses  (1..15)
//   RECOVER_W  cycles after completion before INT is resampled (1..15)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   intReq     in   INT from the master 8259, synchronous to clk
//   intEnable  in   CPU interrupt enable; only gates the start of a sequence
//   dataBus    in   [7:0] PIC data bus, vector valid during pulse 2
//   inta_n     out  INTA strobe to all PICs, active-low, registered
//   vector     out  [7:0] last captured vector, held until the next capture
//   vecValid   out  one-cycle strobe in the cycle vector is updated
//   busy       out  high in every state except IDLE
//   dbg_state  out  [2:0] current FSM state (IDLE encodes as 0)
//
// vecValid is a strobe with no ready/backpressure: the core must take the
// vector in the cycle vecValid is high, or read the held vector later.
// -----------------------------------------------------------------------------
module inta_sequencer #(
  parameter int PULSE_W   = 4,
  parameter int GAP_W     = 2,
  parameter int RECOVER_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intReq,
  input  logic       intEnable,
  input  logic [7:0] dataBus,
  output logic       inta_n,
  output logic [7:0] vector,
  output logic       vecValid,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P1      = 3'd1,
    GAP     = 3'd2,
    P2      = 3'd3,
    DONE    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  localparam logic [3:0] PULSE_LD   = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LD     = 4'(GAP_W - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_W - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       capture;
  logic       start;

  assign start = intReq & intEnable;

  // Next-state / counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = P1;
          cnt_nxt   = PULSE_LD;
        end
      end
      P1: begin
        if (cnt == 4'd0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      GAP: begin
        if (cnt == 4'd0) begin
          state_nxt = P2;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      P2: begin
        if (cnt == 4'd0) begin
          // Capture on the final edge of pulse 2, while inta_n is still low.
          state_nxt = DONE;
          cnt_nxt   = 4'd0;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = RECOVER;
        cnt_nxt   = RECOVER_LD;
      end
      RECOVER: begin
        if (cnt == 4'd0) begin
          // The edge that ends RECOVER is also the first edge at which INT is
          // sampled again, so a still-pending request starts the next
          // sequence directly; otherwise busy drops as IDLE is entered.
          if (start) begin
            state_nxt = P1;
            cnt_nxt   = PULSE_LD;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State register; inta_n and vecValid are registered decodes of the next
  // state so they switch on the same edge as the state and never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      inta_n   <= 1'b1;
      vector   <= 8'h00;
      vecValid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      inta_n   <= !((state_nxt == P1) || (state_nxt == P2));
      vecValid <= (state_nxt == DONE);
      if (capture) begin
        vector <= dataBus;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
